// File: rtl/dsn_slave.sv
// 1-wire slave that emulates a DS2401-class serial-number chip on an open-drain bus.
// It detects the master reset pulse, answers with presence, takes a command byte, then returns rom_id LSB first.
module dsn_slave #(
  parameter int unsigned RST_MIN    = 19200,
  parameter int unsigned PD_WAIT    = 1200,
  parameter int unsigned PD_LEN     = 4800,
  parameter int unsigned SAMPLE_DLY = 1200,
  parameter int unsigned TX_HOLD    = 2400,
  parameter int unsigned MXCNT      = 16
) (
  input  logic        clock,
  input  logic        global_reset,
  input  logic        enable,
  input  logic [63:0] rom_id,
  input  logic        dsn_in,
  output logic        dsn_drive_low,
  output logic        busy,
  output logic [7:0]  rx_cmd,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic        rom_done
);

  localparam int unsigned CW = MXCNT;
  localparam logic [CW-1:0] RST_MIN_C    = CW'(RST_MIN);
  localparam logic [CW-1:0] PD_WAIT_M1   = CW'(PD_WAIT - 1);
  localparam logic [CW-1:0] PD_LEN_M1    = CW'(PD_LEN - 1);
  localparam logic [CW-1:0] SAMPLE_C     = CW'(SAMPLE_DLY);
  localparam logic [CW-1:0] TX_HOLD_M1   = CW'(TX_HOLD - 1);
  localparam logic [5:0]    LAST_CMD_BIT = 6'd7;
  localparam logic [5:0]    LAST_ROM_BIT = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_PD_WAIT,
    ST_PD_DRIVE,
    ST_CMD_RX,
    ST_ROM_TX,
    ST_DONE
  } state_e;

  // Per-slot progress inside CMD_RX / ROM_TX
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ACTIVE,
    PH_WAIT_HIGH
  } phase_e;

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic          sync1_q, sync1_d;
  logic          s_q, s_d;
  logic          s_prev_q, s_prev_d;
  logic [CW-1:0] lo_cnt_q, lo_cnt_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          drive_q, drive_d;
  logic          busy_q, busy_d;
  logic [7:0]    rx_cmd_q, rx_cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_err_q, cmd_err_d;
  logic          rom_done_q, rom_done_d;

  logic          fall;
  logic          rise;
  logic          rst_hit;
  logic [7:0]    sr_shift;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Next-state and output logic
  always_comb begin
    sync1_d     = dsn_in;
    s_d         = sync1_q;
    s_prev_d    = s_q;
    state_d     = state_q;
    phase_d     = phase_q;
    tmr_d       = sat_inc(tmr_q);
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    drive_d     = drive_q;
    rx_cmd_d    = rx_cmd_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    rom_done_d  = 1'b0;

    fall     = s_prev_q & ~s_q;
    rise     = ~s_prev_q & s_q;
    sr_shift = {s_q, sr_q[7:1]};

    // Our own pull-down never counts towards a reset pulse
    lo_cnt_d = (!s_q && !drive_q) ? sat_inc(lo_cnt_q) : '0;

    // Presence generation is protected until the presence pulse is released
    rst_hit = (lo_cnt_q >= RST_MIN_C) &&
              (state_q != ST_RST_LOW) &&
              (state_q != ST_PD_WAIT) &&
              !((state_q == ST_PD_DRIVE) && drive_q);

    if (rst_hit) begin
      state_d = ST_RST_LOW;
      phase_d = PH_IDLE;
      drive_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RST_LOW: begin
          if (rise) begin
            tmr_d   = '0;
            state_d = ST_PD_WAIT;
          end
        end
        ST_PD_WAIT: begin
          if (tmr_q == PD_WAIT_M1) begin
            drive_d = 1'b1;
            tmr_d   = '0;
            state_d = ST_PD_DRIVE;
          end
        end
        ST_PD_DRIVE: begin
          if (drive_q) begin
            if (tmr_q == PD_LEN_M1) drive_d = 1'b0;
          end else if (s_q) begin
            state_d   = ST_CMD_RX;
            phase_d   = PH_IDLE;
            bit_cnt_d = '0;
          end
        end
        ST_CMD_RX: begin
          unique case (phase_q)
            PH_IDLE: begin
              if (fall) begin
                tmr_d   = '0;
                phase_d = PH_ACTIVE;
              end
            end
            PH_ACTIVE: begin
              if (tmr_q == SAMPLE_C) begin
                sr_d    = sr_shift;
                phase_d = PH_WAIT_HIGH;
                if (bit_cnt_q == LAST_CMD_BIT) begin
                  rx_cmd_d    = sr_shift;
                  cmd_valid_d = 1'b1;
                  bit_cnt_d   = '0;
                  if (sr_shift == 8'h33 || sr_shift == 8'h0F) begin
                    state_d = ST_ROM_TX;
                    phase_d = PH_IDLE;
                  end else begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_DONE;
                    phase_d   = PH_IDLE;
                  end
                end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                end
              end
            end
            default: begin
              if (s_q) phase_d = PH_IDLE;
            end
          endcase
        end
        ST_ROM_TX: begin
          unique case (phase_q)
            PH_IDLE: begin
              if (fall) begin
                tmr_d   = '0;
                drive_d = ~rom_id[bit_cnt_q];
                phase_d = PH_ACTIVE;
              end
            end
            PH_ACTIVE: begin
              if (tmr_q == TX_HOLD_M1) begin
                drive_d = 1'b0;
                phase_d = PH_WAIT_HIGH;
              end
            end
            default: begin
              if (s_q && !drive_q) begin
                phase_d = PH_IDLE;
                if (bit_cnt_q == LAST_ROM_BIT) begin
                  rom_done_d = 1'b1;
                  state_d    = ST_DONE;
                  bit_cnt_d  = '0;
                end else begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                end
              end
            end
          endcase
        end
        default: ;
      endcase
    end

    // Disabled: behave as reset but keep the last command byte
    if (!enable) begin
      state_d     = ST_IDLE;
      phase_d     = PH_IDLE;
      lo_cnt_d    = '0;
      tmr_d       = '0;
      bit_cnt_d   = '0;
      sr_d        = '0;
      drive_d     = 1'b0;
      cmd_valid_d = 1'b0;
      cmd_err_d   = 1'b0;
      rom_done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // Registers; the synchroniser resets to the idle-high bus level
  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_IDLE;
      sync1_q     <= 1'b1;
      s_q         <= 1'b1;
      s_prev_q    <= 1'b1;
      lo_cnt_q    <= '0;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      rx_cmd_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      rom_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sync1_q     <= sync1_d;
      s_q         <= s_d;
      s_prev_q    <= s_prev_d;
      lo_cnt_q    <= lo_cnt_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      rx_cmd_q    <= rx_cmd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      rom_done_q  <= rom_done_d;
    end
  end

  assign dsn_drive_low = drive_q;
  assign busy          = busy_q;
  assign rx_cmd        = rx_cmd_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_err       = cmd_err_q;
  assign rom_done      = rom_done_q;

endmodule

// File: tb/tb_dsn_slave.sv
// Directed bench for dsn_slave: a 1-wire master model drives reset, write and read slots.
// Bus timing is shortened by 100x so the full sequence stays short.
module tb_dsn_slave;

  localparam int unsigned RST_MIN    = 192;
  localparam int unsigned PD_WAIT    = 12;
  localparam int unsigned PD_LEN     = 48;
  localparam int unsigned SAMPLE_DLY = 12;
  localparam int unsigned TX_HOLD    = 24;
  localparam logic [63:0] ROM_ID     = 64'hA500_0012_3456_7801;

  logic        clock;
  logic        global_reset;
  logic        enable;
  logic [63:0] rom_id;
  logic        dsn_in;
  logic        dsn_drive_low;
  logic        busy;
  logic [7:0]  rx_cmd;
  logic        cmd_valid;
  logic        cmd_err;
  logic        rom_done;
  logic        master_low;

  int          checks = 0;
  int          failures = 0;
  int          n_valid = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic [7:0]  last_rx = 8'h00;
  logic        drive_seen = 1'b0;

  dsn_slave #(
    .RST_MIN    (RST_MIN),
    .PD_WAIT    (PD_WAIT),
    .PD_LEN     (PD_LEN),
    .SAMPLE_DLY (SAMPLE_DLY),
    .TX_HOLD    (TX_HOLD),
    .MXCNT      (16)
  ) dut (
    .clock         (clock),
    .global_reset  (global_reset),
    .enable        (enable),
    .rom_id        (rom_id),
    .dsn_in        (dsn_in),
    .dsn_drive_low (dsn_drive_low),
    .busy          (busy),
    .rx_cmd        (rx_cmd),
    .cmd_valid     (cmd_valid),
    .cmd_err       (cmd_err),
    .rom_done      (rom_done)
  );

  // Open-drain bus: low if either side pulls
  assign dsn_in = ~(master_low | dsn_drive_low);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (cmd_valid) begin
      n_valid = n_valid + 1;
      last_rx = rx_cmd;
    end
    if (cmd_err)  n_err  = n_err + 1;
    if (rom_done) n_done = n_done + 1;
    if (dsn_drive_low) drive_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_low(input int n);
    master_low = 1'b1;
    clks(n);
    master_low = 1'b0;
  endtask

  task automatic wait_drive(output int lat);
    lat = 0;
    while (!dsn_drive_low && lat < 200) begin
      @(posedge clock);
      #1;
      if (!dsn_drive_low) lat++;
    end
  endtask

  task automatic presence(input string tag);
    int lat;
    int w;
    wait_drive(lat);
    chk({tag, "_lat_in_window"}, 64'(lat >= int'(PD_WAIT) && lat <= int'(PD_WAIT) + 3), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    w = 0;
    while (dsn_drive_low && w < 500) begin
      @(posedge clock);
      #1;
      w++;
    end
    chk({tag, "_width"}, 64'(w), 64'(PD_LEN));
    clks(10);
  endtask

  task automatic write_bit(input logic b);
    bus_low(b ? 4 : 41);
    clks(b ? 78 : 41);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    bus_low(4);
    clks(4);
    b = dsn_in;
    clks(32);
  endtask

  task automatic read_bits(input int n, output logic [63:0] w);
    logic b;
    w = '1;
    for (int k = 0; k < n; k++) begin
      read_bit(b);
      w[k] = b;
    end
  endtask

  initial begin
    logic [63:0] w;
    logic        b;
    int          lat;

    global_reset = 1'b1;
    enable       = 1'b1;
    master_low   = 1'b0;
    rom_id       = ROM_ID;
    clks(4);
    chk("rst_drive",     64'(dsn_drive_low), 64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_rx_cmd",    64'(rx_cmd),        64'h00);
    chk("rst_cmd_valid", 64'(cmd_valid),     64'd0);
    global_reset = 1'b0;
    clks(4);
    chk("idle_busy", 64'(busy), 64'd0);

    // Reset pulse and presence
    bus_low(328);
    presence("pd1");

    // Command 0x33 then full ROM read
    write_byte(8'h33);
    clks(4);
    chk("c33_valid_cnt", 64'(n_valid), 64'd1);
    chk("c33_last_rx",   64'(last_rx), 64'h33);
    chk("c33_rx_cmd",    64'(rx_cmd),  64'h33);
    chk("c33_err_cnt",   64'(n_err),   64'd0);
    chk("c33_busy",      64'(busy),    64'd1);
    read_bits(64, w);
    chk("rom_word", w, ROM_ID);
    chk("rom_done_cnt", 64'(n_done), 64'd1);
    drive_seen = 1'b0;
    read_bit(b);
    chk("slot65_bit",   64'(b),          64'd1);
    chk("slot65_drive", 64'(drive_seen), 64'd0);
    chk("done_busy",    64'(busy),       64'd0);

    // Bad command: error, then silent slots, then presence again
    bus_low(328);
    presence("pd2");
    write_byte(8'hCC);
    clks(4);
    chk("ccc_err_cnt",   64'(n_err),   64'd1);
    chk("ccc_valid_cnt", 64'(n_valid), 64'd2);
    chk("ccc_rx_cmd",    64'(rx_cmd),  64'hCC);
    drive_seen = 1'b0;
    read_bits(64, w);
    chk("ccc_word",  w, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ccc_drive", 64'(drive_seen), 64'd0);
    bus_low(328);
    presence("pd3");

    // Abort ROM_TX at bit 20, then 0x0F restarts from bit 0
    write_byte(8'h33);
    read_bits(20, w);
    chk("part_bits", 64'(w[19:0]), 64'(ROM_ID[19:0]));
    bus_low(328);
    presence("pd4");
    chk("abort_done_cnt", 64'(n_done), 64'd1);
    write_byte(8'h0F);
    chk("c0f_last_rx",   64'(last_rx), 64'h0F);
    chk("c0f_valid_cnt", 64'(n_valid), 64'd4);
    chk("c0f_err_cnt",   64'(n_err),   64'd1);
    read_bits(64, w);
    chk("rom_word2",     w, ROM_ID);
    chk("rom_done_cnt2", 64'(n_done), 64'd2);

    // Disabled slave never drives and keeps rx_cmd
    enable = 1'b0;
    clks(2);
    drive_seen = 1'b0;
    bus_low(328);
    clks(100);
    chk("dis_drive",  64'(drive_seen), 64'd0);
    chk("dis_busy",   64'(busy),       64'd0);
    chk("dis_rx_cmd", 64'(rx_cmd),     64'h0F);
    enable = 1'b1;
    clks(4);

    global_reset = 1'b1;
    clks(3);
    global_reset = 1'b0;
    clks(2);
    chk("grst_rx_cmd", 64'(rx_cmd), 64'h00);

    // Too-short low is not a reset
    drive_seen = 1'b0;
    bus_low(160);
    clks(100);
    chk("short_low_drive", 64'(drive_seen), 64'd0);
    chk("short_low_busy",  64'(busy),       64'd0);

    // global_reset while presence is being driven
    bus_low(328);
    wait_drive(lat);
    chk("pd5_lat_in_window", 64'(lat >= int'(PD_WAIT) && lat <= int'(PD_WAIT) + 3), 64'd1);
    clks(10);
    global_reset = 1'b1;
    @(posedge clock);
    #1;
    chk("grst_pd_drive", 64'(dsn_drive_low), 64'd0);
    chk("grst_pd_busy",  64'(busy),          64'd0);
    @(negedge clock);
    global_reset = 1'b0;
    clks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
